// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: HTRANS/HSIZE encodings, the subordinate FSM state
// type, and the little-endian byte-lane helpers used by the memory slave and cache.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAccess,
    StErr1,
    StErr2
  } ahb_state_e;

  // Little-endian byte lanes touched by a transfer of size hsize at addr_lo.
  function automatic logic [3:0] byte_en(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  // Size is supported and the address is naturally aligned for it.
  function automatic logic size_ok(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic ok;
    case (hsize)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word RAM with per-byte write enables and an asynchronous read port.
// Ports:
//   i_clk    write clock
//   i_idx    word index shared by read and write
//   i_be     byte-lane write enables (lane 0 = bits 7:0)
//   i_wdata  write data
//   o_rdata  combinational read of the word at i_idx
module ahb_mem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [3:0]       i_be,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  // Contents are intentionally not reset.
  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/ahblite3_mem_slave.sv
// AHB-Lite subordinate backed by a byte-addressable word RAM, with programmable
// wait states on OKAY transfers and a two-cycle ERROR response for illegal ones.
// Ports:
//   clk, reset                clock, asynchronous active-low reset
//   io_ahb_H* (inputs)        address/control phase and write data from the manager
//   io_ahb_HRDATA             read data, non-zero only in the access cycle
//   io_ahb_HREADYOUT/HRESP    data-phase completion and response
module ahblite3_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] io_ahb_HADDR,
  input  logic                  io_ahb_HSEL,
  input  logic                  io_ahb_HREADY,
  input  logic                  io_ahb_HWRITE,
  input  logic [2:0]            io_ahb_HSIZE,
  input  logic [2:0]            io_ahb_HBURST,
  input  logic [3:0]            io_ahb_HPROT,
  input  logic [1:0]            io_ahb_HTRANS,
  input  logic                  io_ahb_HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] io_ahb_HWDATA,
  output logic [DATA_WIDTH-1:0] io_ahb_HRDATA,
  output logic                  io_ahb_HREADYOUT,
  output logic                  io_ahb_HRESP
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  ahb_state_e      r_state, w_state_nxt;
  logic [3:0]      r_wait_cnt, w_wait_cnt_nxt;
  logic [IdxW-1:0] r_idx;
  logic [1:0]      r_addr_lo;
  logic            r_write;
  logic [2:0]      r_size;

  logic            w_can_accept;
  logic            w_accept;
  logic            w_oob;
  logic            w_illegal;
  logic [3:0]      w_be;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_unused = ^{io_ahb_HBURST, io_ahb_HPROT, io_ahb_HMASTLOCK};

  // Only states that drive HREADYOUT high may take a new address phase.
  assign w_can_accept = (r_state == StIdle) || (r_state == StAccess) || (r_state == StErr2);
  assign w_accept     = w_can_accept & io_ahb_HSEL & io_ahb_HREADY &
                        ((io_ahb_HTRANS == HTRANS_NONSEQ) || (io_ahb_HTRANS == HTRANS_SEQ));

  // DEPTH_WORDS is a power of two, so any set bit above the index is out of range.
  assign w_oob     = |(io_ahb_HADDR >> (IdxW + 2));
  assign w_illegal = w_oob | ~size_ok(io_ahb_HSIZE, io_ahb_HADDR[1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_wait_cnt <= 4'd0;
      r_idx      <= '0;
      r_addr_lo  <= 2'd0;
      r_write    <= 1'b0;
      r_size     <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_idx     <= io_ahb_HADDR[IdxW+1:2];
        r_addr_lo <= io_ahb_HADDR[1:0];
        r_write   <= io_ahb_HWRITE;
        r_size    <= io_ahb_HSIZE;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    unique case (r_state)
      StWait: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_nxt = StAccess;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      StErr1: w_state_nxt = StErr2;
      StIdle, StAccess, StErr2: begin
        if (!w_accept) begin
          w_state_nxt = StIdle;
        end else if (w_illegal) begin
          w_state_nxt = StErr1;
        end else if (WAIT_STATES == 0) begin
          w_state_nxt = StAccess;
        end else begin
          w_state_nxt    = StWait;
          w_wait_cnt_nxt = WaitLoad;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Error transfers never reach StAccess, so they can never write.
  assign w_be = ((r_state == StAccess) && r_write) ? byte_en(r_size, r_addr_lo) : 4'b0000;

  ahb_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IdxW)
  ) u_mem (
    .i_clk  (clk),
    .i_idx  (r_idx),
    .i_be   (w_be),
    .i_wdata(io_ahb_HWDATA),
    .o_rdata(w_rdata)
  );

  assign io_ahb_HREADYOUT = ~((r_state == StWait) || (r_state == StErr1));
  assign io_ahb_HRESP     = (r_state == StErr1) || (r_state == StErr2);
  assign io_ahb_HRDATA    = (r_state == StAccess) ? w_rdata : '0;

endmodule

// File: tb/tb_ahblite3_mem_slave.sv
module tb_ahblite3_mem_slave;
  import ahb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [23:0] haddr = '0;
  logic        hsel = 1'b0, hwrite = 1'b0, hmastlock = 1'b0;
  logic [2:0]  hsize = '0, hburst = '0;
  logic [3:0]  hprot = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [31:0] hwdata = '0;
  int          sel = 0;

  logic        hsel0, hsel1, hro0, hro1, hresp0, hresp1, hro, hresp;
  logic [31:0] hrdata0, hrdata1, hrdata;
  assign hsel0  = hsel && (sel == 0);
  assign hsel1  = hsel && (sel == 1);
  assign hro    = (sel == 1) ? hro1 : hro0;
  assign hresp  = (sel == 1) ? hresp1 : hresp0;
  assign hrdata = (sel == 1) ? hrdata1 : hrdata0;

  ahblite3_mem_slave #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .io_ahb_HADDR(haddr), .io_ahb_HSEL(hsel0),
    .io_ahb_HREADY(hro0), .io_ahb_HWRITE(hwrite), .io_ahb_HSIZE(hsize),
    .io_ahb_HBURST(hburst), .io_ahb_HPROT(hprot), .io_ahb_HTRANS(htrans),
    .io_ahb_HMASTLOCK(hmastlock), .io_ahb_HWDATA(hwdata), .io_ahb_HRDATA(hrdata0),
    .io_ahb_HREADYOUT(hro0), .io_ahb_HRESP(hresp0)
  );

  ahblite3_mem_slave #(.WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset(rst_n), .io_ahb_HADDR(haddr), .io_ahb_HSEL(hsel1),
    .io_ahb_HREADY(hro1), .io_ahb_HWRITE(hwrite), .io_ahb_HSIZE(hsize),
    .io_ahb_HBURST(hburst), .io_ahb_HPROT(hprot), .io_ahb_HTRANS(htrans),
    .io_ahb_HMASTLOCK(hmastlock), .io_ahb_HWDATA(hwdata), .io_ahb_HRDATA(hrdata1),
    .io_ahb_HREADYOUT(hro1), .io_ahb_HRESP(hresp1)
  );

  localparam int MaxTx = 64;
  logic [23:0] t_addr  [MaxTx];
  logic        t_write [MaxTx];
  logic [2:0]  t_size  [MaxTx];
  logic [1:0]  t_trans [MaxTx];
  logic        t_sel   [MaxTx];
  logic [31:0] t_wdata [MaxTx];
  logic [31:0] o_rdata [MaxTx];
  logic        o_resp  [MaxTx];
  logic        o_errlow[MaxTx];
  int          o_waits [MaxTx];
  int          n_tx;
  int          total = 0;
  int          bad = 0;

  task automatic add_tx(input logic [23:0] a, input logic w, input logic [2:0] s,
                        input logic [1:0] tr, input logic [31:0] d, input logic sl);
    t_addr[n_tx] = a; t_write[n_tx] = w; t_size[n_tx] = s;
    t_trans[n_tx] = tr; t_wdata[n_tx] = d; t_sel[n_tx] = sl;
    n_tx++;
  endtask

  task automatic drive_addr(input int i);
    hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
    if (i < n_tx) begin
      haddr = t_addr[i]; hwrite = t_write[i]; hsize = t_size[i];
      htrans = t_trans[i]; hsel = t_sel[i];
    end else begin
      haddr = 24'($urandom); hwrite = 1'b0; hsize = 3'd2; htrans = HTRANS_IDLE; hsel = 1'b0;
    end
  endtask

  // Pipelined manager: inputs change 1 time unit after posedge, outputs sampled at negedge.
  task automatic bus_run();
    int  pend = -1;
    int  cur = 0;
    int  cyc = 0;
    logic rdy;
    for (int i = 0; i < n_tx; i++) begin
      o_waits[i] = 0; o_errlow[i] = 1'b0; o_rdata[i] = 'x; o_resp[i] = 1'bx;
    end
    @(posedge clk); #1;
    drive_addr(0);
    while (!(cur >= n_tx && pend < 0)) begin
      if (cyc >= 400) begin
        total++; bad++;
        $display("FAIL bus_run timeout: got pending=%0d expected all %0d done", pend, n_tx);
        break;
      end
      @(negedge clk);
      cyc++;
      rdy = hro;
      if (pend >= 0) begin
        if (!rdy) begin
          o_waits[pend]++;
          if (hresp) o_errlow[pend] = 1'b1;
        end else begin
          o_rdata[pend] = hrdata;
          o_resp[pend]  = hresp;
        end
      end
      if (rdy) begin
        if (cur < n_tx) begin pend = cur; cur++; end
        else pend = -1;
      end
      @(posedge clk); #1;
      drive_addr(cur);
      hwdata = (pend >= 0 && t_write[pend]) ? t_wdata[pend] : $urandom();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 6;
    if (hro0 !== 1'b1)     begin bad++; $display("FAIL reset hready0: got %b expected 1", hro0); end
    if (hresp0 !== 1'b0)   begin bad++; $display("FAIL reset hresp0: got %b expected 0", hresp0); end
    if (hrdata0 !== 32'h0) begin bad++; $display("FAIL reset hrdata0: got %h expected 0", hrdata0); end
    if (hro1 !== 1'b1)     begin bad++; $display("FAIL reset hready1: got %b expected 1", hro1); end
    if (hresp1 !== 1'b0)   begin bad++; $display("FAIL reset hresp1: got %b expected 0", hresp1); end
    if (hrdata1 !== 32'h0) begin bad++; $display("FAIL reset hrdata1: got %h expected 0", hrdata1); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    sel = 0; n_tx = 0;
    add_tx(24'h000010, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'hDEADBEEF, 1'b1);
    add_tx(24'h000010, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 1'b1);
    bus_run();
    total += 4;
    if (o_rdata[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b rdata: got %h expected deadbeef", o_rdata[1]); end
    if (o_waits[0] != 0 || o_waits[1] != 0) begin
      bad++; $display("FAIL b2b waits: got %0d/%0d expected 0/0", o_waits[0], o_waits[1]);
    end
    if (o_resp[0] !== 1'b0) begin bad++; $display("FAIL b2b resp0: got %b expected 0", o_resp[0]); end
    if (o_resp[1] !== 1'b0) begin bad++; $display("FAIL b2b resp1: got %b expected 0", o_resp[1]); end
  endtask

  task automatic test_byte_write();
    sel = 0; n_tx = 0;
    add_tx(24'h000010, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h11223344, 1'b1);
    add_tx(24'h000013, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ, 32'hAA000000, 1'b1);
    add_tx(24'h000010, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 1'b1);
    bus_run();
    total += 1;
    if (o_rdata[2] !== 32'hAA223344) begin bad++; $display("FAIL byte_write rdata: got %h expected aa223344", o_rdata[2]); end
  endtask

  task automatic test_wait_states();
    sel = 1; n_tx = 0;
    add_tx(24'h000040, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'hCAFEF00D, 1'b1);
    add_tx(24'h000044, 1'b1, HSIZE_WORD, HTRANS_SEQ, 32'h01234567, 1'b1);
    add_tx(24'h000040, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 1'b1);
    add_tx(24'h000044, 1'b0, HSIZE_WORD, HTRANS_SEQ, 32'h0, 1'b1);
    bus_run();
    total += 6;
    for (int i = 0; i < 4; i++) begin
      if (o_waits[i] != 3 || o_errlow[i] !== 1'b0) begin
        bad++; $display("FAIL ws3 waits[%0d]: got %0d resp_low=%b expected 3 resp_low=0", i, o_waits[i], o_errlow[i]);
      end
    end
    if (o_rdata[2] !== 32'hCAFEF00D) begin bad++; $display("FAIL ws3 rdata0: got %h expected cafef00d", o_rdata[2]); end
    if (o_rdata[3] !== 32'h01234567) begin bad++; $display("FAIL ws3 rdata1: got %h expected 01234567", o_rdata[3]); end
  endtask

  task automatic test_errors();
    sel = 0; n_tx = 0;
    add_tx(24'h000000, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h55AA55AA, 1'b1);
    add_tx(24'h000002, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'hFFFFFFFF, 1'b1);
    add_tx(24'h000000, 1'b1, 3'd3,       HTRANS_NONSEQ, 32'h00000000, 1'b1);
    add_tx(24'h001000, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 1'b1);
    add_tx(24'h000000, 1'b1, HSIZE_WORD, HTRANS_BUSY,   32'h12121212, 1'b1);
    add_tx(24'h000000, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 1'b1);
    bus_run();
    for (int i = 1; i <= 3; i++) begin
      total += 3;
      if (o_waits[i] != 1) begin bad++; $display("FAIL err[%0d] waits: got %0d expected 1", i, o_waits[i]); end
      if (o_errlow[i] !== 1'b1 || o_resp[i] !== 1'b1) begin
        bad++; $display("FAIL err[%0d] hresp: got %b,%b expected 1,1", i, o_errlow[i], o_resp[i]);
      end
      if (o_rdata[i] !== 32'h0) begin bad++; $display("FAIL err[%0d] rdata: got %h expected 0", i, o_rdata[i]); end
    end
    total += 3;
    if (o_waits[4] != 0 || o_resp[4] !== 1'b0) begin
      bad++; $display("FAIL busy: got waits=%0d resp=%b expected 0,0", o_waits[4], o_resp[4]);
    end
    if (o_rdata[5] !== 32'h55AA55AA) begin bad++; $display("FAIL err ram: got %h expected 55aa55aa", o_rdata[5]); end
    if (o_waits[5] != 0) begin bad++; $display("FAIL err after waits: got %0d expected 0", o_waits[5]); end
  endtask

  task automatic test_reset_mid_wait();
    sel = 1; n_tx = 0;
    add_tx(24'h000020, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h0BADF00D, 1'b1);
    bus_run();
    @(posedge clk); #1;
    haddr = 24'h000020; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ; hsel = 1'b1;
    @(posedge clk); #1;
    htrans = HTRANS_IDLE; hsel = 1'b0; hwdata = 32'h12345678;
    @(negedge clk);
    total += 4;
    if (hro1 !== 1'b0) begin bad++; $display("FAIL rst_wait entered: got hready=%b expected 0", hro1); end
    rst_n = 1'b0;
    #1;
    if (hro1 !== 1'b1)     begin bad++; $display("FAIL rst_wait hready: got %b expected 1", hro1); end
    if (hresp1 !== 1'b0)   begin bad++; $display("FAIL rst_wait hresp: got %b expected 0", hresp1); end
    if (hrdata1 !== 32'h0) begin bad++; $display("FAIL rst_wait hrdata: got %h expected 0", hrdata1); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_tx = 0;
    add_tx(24'h000020, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 1'b1);
    bus_run();
    total += 1;
    if (o_rdata[0] !== 32'h0BADF00D) begin bad++; $display("FAIL rst_wait ram: got %h expected 0badf00d", o_rdata[0]); end
  endtask

  // Reference: sequential memory image over a 16-word region at 0x100, driven by the bus rules.
  task automatic test_random();
    logic [31:0] mdl [16];
    logic [31:0] e_rdata [MaxTx];
    int          e_waits [MaxTx];
    logic        e_err   [MaxTx];
    logic        e_chk   [MaxTx];
    for (int s = 0; s < 2; s++) begin
      int ws = (s == 1) ? 3 : 0;
      sel = s; n_tx = 0;
      for (int w = 0; w < 16; w++) begin
        mdl[w] = $urandom();
        add_tx(24'(32'h100 + 4 * w), 1'b1, HSIZE_WORD, HTRANS_NONSEQ, mdl[w], 1'b1);
      end
      bus_run();
      n_tx = 0;
      for (int i = 0; i < 40; i++) begin
        int          kind = $urandom_range(0, 9);
        int          sub  = $urandom_range(0, 3);
        logic [23:0] a    = 24'(32'h100 + 4 * $urandom_range(0, 15));
        logic [2:0]  sz   = HSIZE_WORD;
        logic [1:0]  tr   = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
        logic        sl   = 1'b1;
        int unsigned ua;
        logic        active, legal;
        if (kind == 0) begin
          if (sub == 0) tr = HTRANS_BUSY;
          else if (sub == 1) tr = HTRANS_IDLE;
          else sl = 1'b0;
        end else if (kind == 1) begin
          if (sub == 0) sz = 3'($urandom_range(3, 7));
          else if (sub == 1) begin sz = HSIZE_HALF; a = a + 24'd1 + 24'(2 * $urandom_range(0, 1)); end
          else if (sub == 2) a = a + 24'($urandom_range(1, 3));
          else a = 24'($urandom_range(32'h1000, 32'hFFFFFF)) & 24'hFFFFFC;
        end else begin
          sz = 3'($urandom_range(0, 2));
          if (sz == HSIZE_BYTE) a = a + 24'($urandom_range(0, 3));
          else if (sz == HSIZE_HALF) a = a + 24'(2 * $urandom_range(0, 1));
        end
        add_tx(a, 1'($urandom), sz, tr, $urandom(), sl);
        ua     = 32'(a);
        active = sl && (tr == HTRANS_NONSEQ || tr == HTRANS_SEQ);
        legal  = (sz <= 3'd2) && (ua % (1 << sz) == 0) && (ua / 4 < 1024);
        e_chk[i] = 1'b1; e_rdata[i] = 32'h0;
        if (!active) begin
          e_waits[i] = 0; e_err[i] = 1'b0;
        end else if (!legal) begin
          e_waits[i] = 1; e_err[i] = 1'b1;
        end else begin
          int idx = int'((ua - 32'h100) / 4);
          e_waits[i] = ws; e_err[i] = 1'b0;
          if (t_write[i]) begin
            int off = int'(ua % 4);
            e_chk[i] = 1'b0;
            for (int k = 0; k < (1 << sz); k++) mdl[idx][8*(off+k) +: 8] = t_wdata[i][8*(off+k) +: 8];
          end else begin
            e_rdata[i] = mdl[idx];
          end
        end
      end
      bus_run();
      for (int i = 0; i < 40; i++) begin
        total += 3;
        if (o_waits[i] != e_waits[i]) begin
          bad++; $display("FAIL rand%0d[%0d] waits: got %0d expected %0d", s, i, o_waits[i], e_waits[i]);
        end
        if (o_resp[i] !== e_err[i] || o_errlow[i] !== e_err[i]) begin
          bad++; $display("FAIL rand%0d[%0d] hresp: got %b,%b expected %b", s, i, o_errlow[i], o_resp[i], e_err[i]);
        end
        if (e_chk[i] && o_rdata[i] !== e_rdata[i]) begin
          bad++; $display("FAIL rand%0d[%0d] rdata: got %h expected %h", s, i, o_rdata[i], e_rdata[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_write();
    test_wait_states();
    test_errors();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahblite3_mem_slave.md
# ahblite3_mem_slave

AHB-Lite 3 subordinate that backs the memory-side master port of `Ahblite3Cache` with a byte-addressable word RAM. It answers the cache's refill reads and write-backs, and adds programmable wait states and error responses so the cache's miss path can be stressed in simulation. It is also synthesizable as an on-chip SRAM target.

## Interface
- ADDR_WIDTH, 24: HADDR width.
- DATA_WIDTH, 32: HRDATA/HWDATA width. Only 32 is supported.
- DEPTH_WORDS, 1024: RAM depth in 32-bit words. Must be a power of two.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted into every OKAY data phase. Range 0–15.

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  reset; asynchronous, active-low
- io_ahb_HADDR  in  ADDR_WIDTH  byte address
- io_ahb_HSEL  in  1  subordinate select
- io_ahb_HREADY  in  1  bus ready; previous data phase complete
- io_ahb_HWRITE  in  1  1 = write
- io_ahb_HSIZE  in  3  transfer size
- io_ahb_HBURST  in  3  ignored; every beat is decoded on its own
- io_ahb_HPROT  in  4  ignored
- io_ahb_HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- io_ahb_HMASTLOCK  in  1  ignored
- io_ahb_HWDATA  in  32  write data, valid in the data phase
- io_ahb_HRDATA  out  32  read data
- io_ahb_HREADYOUT  out  1  data-phase completion
- io_ahb_HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Address-phase accept condition: HSEL & HREADY & HTRANS[1]. On accept, register HADDR, HWRITE and HSIZE, and decode legality.
- Illegal transfer, if any of:
  - HSIZE > 2
  - misaligned: half with HADDR[0]=1, or word with HADDR[1:0]≠0
  - word index HADDR[ADDR_WIDTH-1:2] ≥ DEPTH_WORDS
- IDLE, BUSY, or not selected: no state change. The next data phase is a zero-wait OKAY.
- State machine:
  - IDLE: on legal accept with WAIT_STATES=0 → ACCESS. With WAIT_STATES>0 → WAIT, load wait counter = WAIT_STATES−1. On illegal accept → ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements; at 0 → ACCESS.
  - ACCESS: HREADYOUT=1, HRESP=0. The transfer completes. A new accept in this cycle re-enters WAIT, ACCESS or ERR1 by the IDLE rules; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accepts the next address phase by the IDLE rules. The master may also cancel by driving IDLE.
- Writes:
  - RAM is written in the ACCESS cycle from HWDATA.
  - Byte enables are little-endian by HSIZE and HADDR[1:0]: byte → 1 lane; half → lanes {1:0} or {3:2}; word → all lanes.
  - Error transfers never write.
- Reads:
  - HRDATA = full RAM word at the registered index, combinational from the array; valid in the ACCESS cycle. Byte and half reads return the whole word; the master selects the lane.
  - Outside ACCESS, HRDATA holds 0.
- Back-to-back write-then-read to the same word: the write commits at the end of ACCESS, so the read's data phase returns the new value.
- Reset (asserted at any time, including mid-transfer):
  - state → IDLE, wait counter → 0
  - HREADYOUT=1, HRESP=0, HRDATA=0
  - any in-flight write is dropped
  - RAM contents are not reset

## Timing
- Latency from accept to completion: 1 + WAIT_STATES cycles for OKAY transfers; exactly 2 cycles for ERROR.
- Pipelining: the next address phase overlaps the current completing cycle, so sustained throughput is 1 beat per (1 + WAIT_STATES) cycles.
- Address-phase signals are sampled only when HREADY=1. While HREADYOUT=0, bus changes are ignored.
- HRESP stays stable for both ERROR cycles.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS_* and HSIZE_* constants
  - the state enum {IDLE, WAIT, ACCESS, ERR1, ERR2}
  - a `byte_en(hsize, addr_lo)` function, reused by the cache
- One sub-module: `ahb_mem_array`, a DEPTH_WORDS×32 RAM with a 4-bit byte-enable write port and an asynchronous read port.

## Test plan
- WAIT_STATES=0: write word 0xDEADBEEF @0x000010, then read @0x000010 back-to-back → HRDATA=0xDEADBEEF, HREADYOUT never low.
- Byte write 0xAA @0x000013 over word 0x11223344 → word read returns 0xAA223344.
- WAIT_STATES=3: NONSEQ read followed by SEQ read → each data phase has HREADYOUT low 3 cycles then high; both words correct.
- Word access @0x000002 and HSIZE=3 → two-cycle ERROR (HREADYOUT 0 then 1, HRESP 1 both cycles); RAM unchanged.
- Read @word index DEPTH_WORDS → ERROR. A BUSY beat → zero-wait OKAY, no RAM access.
- Reset asserted mid-WAIT of a write → outputs HREADYOUT=1, HRESP=0, HRDATA=0 immediately; target word keeps its old value.
